core_mem_arb: RTL and testbench



---
 rtl/core_mem_arb_if.sv | 52 +++++
 rtl/core_mem_arb.sv | 130 +++++++++++++
 tb/tb_core_mem_arb.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/core_mem_arb_if.sv
// Purpose : bundles the fetch, data and downstream memory handshakes of core_mem_arb.
// Latency : none (wires only).
// Backpressure: the val/ack pairs carry it; a requester holds val and its fields until ack.
//
// Signals:
//   i_req_*   instruction-fetch request (read-only) and its ack/rdata
//   d_req_*   data request (read/write) and its ack/rdata
//   mem_req_* shared downstream request; mem_req_ack/mem_ack_rdata complete it
//   arb_timeout_err  watchdog-abort pulse, aligned with the owner's ack
// Modports: slave = the arbiter's view, master = the core/memory side.
interface core_mem_arb_if;
  logic        i_req_val;
  logic [31:0] i_req_addr;
  logic        i_req_ack;
  logic [31:0] i_ack_rdata;

  logic        d_req_val;
  logic [31:0] d_req_addr;
  logic [2:0]  d_req_cop;
  logic [31:0] d_req_wdata;
  logic [2:0]  d_req_size;
  logic        d_req_ack;
  logic [31:0] d_ack_rdata;

  logic        mem_req_val;
  logic [31:0] mem_req_addr;
  logic [2:0]  mem_req_cop;
  logic [31:0] mem_req_wdata;
  logic [2:0]  mem_req_size;
  logic        mem_req_ack;
  logic [31:0] mem_ack_rdata;

  logic        arb_timeout_err;

  modport slave (
    input  i_req_val, i_req_addr,
    input  d_req_val, d_req_addr, d_req_cop, d_req_wdata, d_req_size,
    input  mem_req_ack, mem_ack_rdata,
    output i_req_ack, i_ack_rdata, d_req_ack, d_ack_rdata,
    output mem_req_val, mem_req_addr, mem_req_cop, mem_req_wdata, mem_req_size,
    output arb_timeout_err
  );

  modport master (
    output i_req_val, i_req_addr,
    output d_req_val, d_req_addr, d_req_cop, d_req_wdata, d_req_size,
    output mem_req_ack, mem_ack_rdata,
    input  i_req_ack, i_ack_rdata, d_req_ack, d_ack_rdata,
    input  mem_req_val, mem_req_addr, mem_req_cop, mem_req_wdata, mem_req_size,
    input  arb_timeout_err
  );
endinterface

// File: rtl/core_mem_arb.sv
// Purpose : round-robin arbiter sharing one memory port between fetch (I) and data (D), one outstanding transaction.
// Latency : req val sampled at T -> mem_req_val at T+1; mem_req_ack at A -> owner ack at A+1 (3-cycle minimum round trip).
// Backpressure: requesters hold val until their ack; BUSY waits for mem_req_ack (bounded only with the watchdog).
//
// Ports: core_sys_clk (rising edge), core_sys_rst (synchronous, active-high),
//        bus (core_mem_arb_if.slave: i_req_*, d_req_*, mem_req_*, arb_timeout_err).
// Option: define CORE_ARB_TIMEOUT_EN to enable the BUSY watchdog (TIMEOUT_CYCLES);
//         without it BUSY waits forever and arb_timeout_err is constant 0.
module core_mem_arb #(
  parameter int         TIMEOUT_CYCLES = 256,
  parameter logic [2:0] I_COP          = 3'b000,
  parameter logic [2:0] I_SIZE         = 3'b010
) (
  input  logic          core_sys_clk,
  input  logic          core_sys_rst,
  core_mem_arb_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef enum logic       {OWN_I, OWN_D}     own_t;

  state_t      state, state_nxt;
  own_t        own, last, grant;
  logic        any_req;
  logic        timeout_hit;
  logic        err_q;
  logic [31:0] req_addr, req_wdata, resp_rdata;
  logic [2:0]  req_cop, req_size;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("core_mem_arb: TIMEOUT_CYCLES must be at least 1");
  end

  assign any_req = bus.i_req_val | bus.d_req_val;

  // State register
  always_ff @(posedge core_sys_clk) begin
    if (core_sys_rst) state <= IDLE;
    else              state <= state_nxt;
  end

  // Next state and grant selection
  always_comb begin
    state_nxt = state;
    grant     = OWN_I;
    case (state)
      IDLE: begin
        // On a tie the requester that was not served last wins.
        if (bus.i_req_val && bus.d_req_val) grant = (last == OWN_I) ? OWN_D : OWN_I;
        else if (bus.d_req_val)             grant = OWN_D;
        else                                grant = OWN_I;
        if (any_req) state_nxt = BUSY;
      end
      BUSY:    if (bus.mem_req_ack || timeout_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request/response registers; only loaded from IDLE (request) or BUSY (response).
  always_ff @(posedge core_sys_clk) begin
    if (core_sys_rst) begin
      own        <= OWN_I;
      last       <= OWN_D;
      req_addr   <= '0;
      req_cop    <= '0;
      req_wdata  <= '0;
      req_size   <= '0;
      resp_rdata <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        own  <= grant;
        last <= grant;
        if (grant == OWN_I) begin
          req_addr  <= bus.i_req_addr;
          req_cop   <= I_COP;
          req_wdata <= '0;
          req_size  <= I_SIZE;
        end else begin
          req_addr  <= bus.d_req_addr;
          req_cop   <= bus.d_req_cop;
          req_wdata <= bus.d_req_wdata;
          req_size  <= bus.d_req_size;
        end
      end
      if (state == BUSY) begin
        // A real completion in the limit cycle takes priority over the abort.
        if (bus.mem_req_ack)  resp_rdata <= bus.mem_ack_rdata;
        else if (timeout_hit) resp_rdata <= 32'hDEAD_BEEF;
      end
    end
  end

`ifdef CORE_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;

  // Counter holds (BUSY cycles - 1); the limit-th BUSY cycle aborts.
  assign timeout_hit = (state == BUSY) && !bus.mem_req_ack &&
                       (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge core_sys_clk) begin
    if (core_sys_rst) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == BUSY) wd_cnt <= wd_cnt + 1'b1;
      else               wd_cnt <= '0;
      // Lands in the RESP cycle, alongside the owner's ack.
      err_q <= timeout_hit;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_q       = 1'b0;
`endif

  // Outputs decode registered state only; no input reaches them combinationally.
  assign bus.mem_req_val     = (state == BUSY);
  assign bus.mem_req_addr    = req_addr;
  assign bus.mem_req_cop     = req_cop;
  assign bus.mem_req_wdata   = req_wdata;
  assign bus.mem_req_size    = req_size;
  assign bus.i_req_ack       = (state == RESP) && (own == OWN_I);
  assign bus.d_req_ack       = (state == RESP) && (own == OWN_D);
  assign bus.i_ack_rdata     = resp_rdata;
  assign bus.d_ack_rdata     = resp_rdata;
  assign bus.arb_timeout_err = err_q;

endmodule

// File: tb/tb_core_mem_arb.sv
// Purpose : directed self-checking bench for core_mem_arb.
// Latency : inputs driven 1 time unit after a rising edge, outputs checked at that same point.
// Backpressure: the bench plays both requesters and the memory, acking by hand.
module tb_core_mem_arb;

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  core_mem_arb_if bus ();

  core_mem_arb #(
    .TIMEOUT_CYCLES(8),
    .I_COP         (3'b000),
    .I_SIZE        (3'b010)
  ) dut (
    .core_sys_clk(clk),
    .core_sys_rst(rst),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst               = 1'b1;
    bus.i_req_val     = 1'b0;
    bus.i_req_addr    = '0;
    bus.d_req_val     = 1'b0;
    bus.d_req_addr    = '0;
    bus.d_req_cop     = '0;
    bus.d_req_wdata   = '0;
    bus.d_req_size    = '0;
    bus.mem_req_ack   = 1'b0;
    bus.mem_ack_rdata = '0;

    // Reset defaults
    tick();
    tick();
    rst = 1'b0;
    chk1 ("rst_mem_val",  bus.mem_req_val, 1'b0);
    chk1 ("rst_i_ack",    bus.i_req_ack, 1'b0);
    chk1 ("rst_d_ack",    bus.d_req_ack, 1'b0);
    chk1 ("rst_err",      bus.arb_timeout_err, 1'b0);
    chk32("rst_mem_addr", bus.mem_req_addr, 32'h0);
    chk32("rst_mem_wdat", bus.mem_req_wdata, 32'h0);
    chk32("rst_mem_cop",  {29'h0, bus.mem_req_cop}, 32'h0);
    chk32("rst_mem_size", {29'h0, bus.mem_req_size}, 32'h0);
    chk32("rst_i_rdata",  bus.i_ack_rdata, 32'h0);
    chk32("rst_d_rdata",  bus.d_ack_rdata, 32'h0);

    // Stray memory ack in IDLE is ignored
    bus.mem_req_ack   = 1'b1;
    bus.mem_ack_rdata = 32'h0000_0055;
    tick();
    bus.mem_req_ack = 1'b0;
    chk1 ("idle_ack_i",    bus.i_req_ack, 1'b0);
    chk1 ("idle_ack_d",    bus.d_req_ack, 1'b0);
    chk1 ("idle_ack_val",  bus.mem_req_val, 1'b0);
    chk32("idle_ack_rdat", bus.i_ack_rdata, 32'h0);

    // Single fetch: raise at T, memory acks at T+3, i ack at T+4
    bus.i_req_val  = 1'b1;
    bus.i_req_addr = 32'h0000_0100;
    tick();
    chk1 ("fetch_val_t1",  bus.mem_req_val, 1'b1);
    chk32("fetch_addr",    bus.mem_req_addr, 32'h0000_0100);
    chk32("fetch_cop",     {29'h0, bus.mem_req_cop}, 32'h0);
    chk32("fetch_size",    {29'h0, bus.mem_req_size}, 32'h2);
    chk32("fetch_wdata",   bus.mem_req_wdata, 32'h0);
    tick();
    chk1 ("fetch_val_t2",  bus.mem_req_val, 1'b1);
    tick();
    chk1 ("fetch_val_t3",  bus.mem_req_val, 1'b1);
    bus.mem_req_ack   = 1'b1;
    bus.mem_ack_rdata = 32'h0000_0013;
    tick();
    bus.mem_req_ack = 1'b0;
    chk1 ("fetch_i_ack",   bus.i_req_ack, 1'b1);
    chk32("fetch_rdata",   bus.i_ack_rdata, 32'h0000_0013);
    chk1 ("fetch_d_ack",   bus.d_req_ack, 1'b0);
    chk1 ("fetch_val_t4",  bus.mem_req_val, 1'b0);
    chk1 ("fetch_err",     bus.arb_timeout_err, 1'b0);
    bus.i_req_val = 1'b0;
    tick();
    chk1 ("fetch_ack_1cy", bus.i_req_ack, 1'b0);

    // Simultaneous requests after reset: I first, D waits through I's BUSY
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    bus.i_req_val   = 1'b1;
    bus.i_req_addr  = 32'h0000_0100;
    bus.d_req_val   = 1'b1;
    bus.d_req_addr  = 32'h0000_2000;
    bus.d_req_cop   = 3'b101;
    bus.d_req_wdata = 32'hCAFE_F00D;
    bus.d_req_size  = 3'b001;
    tick();
    chk1 ("tie_val",       bus.mem_req_val, 1'b1);
    chk32("tie_i_first",   bus.mem_req_addr, 32'h0000_0100);
    tick();
    chk32("busy_hold_a1",  bus.mem_req_addr, 32'h0000_0100);
    tick();
    chk32("busy_hold_a2",  bus.mem_req_addr, 32'h0000_0100);
    bus.mem_req_ack   = 1'b1;
    bus.mem_ack_rdata = 32'h0000_0011;
    tick();
    bus.mem_req_ack = 1'b0;
    chk1 ("tie_i_ack",     bus.i_req_ack, 1'b1);
    chk1 ("tie_d_noack",   bus.d_req_ack, 1'b0);
    chk32("resp_hold_a",   bus.mem_req_addr, 32'h0000_0100);
    bus.i_req_val = 1'b0;
    tick();
    chk1 ("tie_idle_val",  bus.mem_req_val, 1'b0);
    tick();
    chk1 ("d_val",         bus.mem_req_val, 1'b1);
    chk32("d_addr",        bus.mem_req_addr, 32'h0000_2000);
    chk32("d_cop",         {29'h0, bus.mem_req_cop}, 32'h5);
    chk32("d_wdata",       bus.mem_req_wdata, 32'hCAFE_F00D);
    chk32("d_size",        {29'h0, bus.mem_req_size}, 32'h1);
    bus.mem_req_ack   = 1'b1;
    bus.mem_ack_rdata = 32'h0000_0022;
    tick();
    bus.mem_req_ack = 1'b0;
    chk1 ("d_ack",         bus.d_req_ack, 1'b1);
    chk1 ("d_i_noack",     bus.i_req_ack, 1'b0);
    chk32("d_rdata",       bus.d_ack_rdata, 32'h0000_0022);
    bus.d_req_val = 1'b0;
    tick();

    // Continuous contention: D was served last, so order is I, D, I, D
    bus.i_req_val = 1'b1;
    bus.d_req_val = 1'b1;
    for (int k = 0; k < 4; k++) begin
      int waited;
      waited = 0;
      while (bus.mem_req_val !== 1'b1 && waited < 10) begin
        tick();
        waited++;
      end
      chk1 ("rr_grant_val", bus.mem_req_val, 1'b1);
      chk32("rr_grant_addr", bus.mem_req_addr, (k % 2 == 0) ? 32'h0000_0100 : 32'h0000_2000);
      bus.mem_req_ack   = 1'b1;
      bus.mem_ack_rdata = 32'h0000_1000 + k;
      tick();
      bus.mem_req_ack = 1'b0;
      chk1 ("rr_i_ack",  bus.i_req_ack, (k % 2 == 0));
      chk1 ("rr_d_ack",  bus.d_req_ack, (k % 2 == 1));
      chk32("rr_rdata",  bus.i_ack_rdata, 32'h0000_1000 + k);
    end
    bus.i_req_val = 1'b0;
    bus.d_req_val = 1'b0;
    tick();
    tick();

    // Reset while BUSY drops the transaction
    bus.d_req_val  = 1'b1;
    bus.d_req_addr = 32'h0000_3000;
    tick();
    chk1 ("mid_busy_val",  bus.mem_req_val, 1'b1);
    rst           = 1'b1;
    bus.d_req_val = 1'b0;
    tick();
    rst = 1'b0;
    chk1 ("mid_rst_val",   bus.mem_req_val, 1'b0);
    chk1 ("mid_rst_i_ack", bus.i_req_ack, 1'b0);
    chk1 ("mid_rst_d_ack", bus.d_req_ack, 1'b0);
    chk32("mid_rst_addr",  bus.mem_req_addr, 32'h0);
    bus.mem_req_ack   = 1'b1;
    bus.mem_ack_rdata = 32'h0000_0077;
    tick();
    bus.mem_req_ack = 1'b0;
    chk1 ("late_ack_d",    bus.d_req_ack, 1'b0);
    tick();
    chk1 ("late_ack_d2",   bus.d_req_ack, 1'b0);
    chk1 ("late_ack_val",  bus.mem_req_val, 1'b0);

`ifdef CORE_ARB_TIMEOUT_EN
    // Watchdog: 8 BUSY cycles without ack, then RESP with DEAD_BEEF and error
    bus.d_req_val  = 1'b1;
    bus.d_req_addr = 32'h0000_4000;
    for (int c = 1; c <= 8; c++) begin
      tick();
      chk1("to_busy_val", bus.mem_req_val, 1'b1);
    end
    tick();
    chk1 ("to_val_drop",  bus.mem_req_val, 1'b0);
    chk1 ("to_d_ack",     bus.d_req_ack, 1'b1);
    chk32("to_rdata",     bus.d_ack_rdata, 32'hDEAD_BEEF);
    chk1 ("to_err",       bus.arb_timeout_err, 1'b1);
    bus.d_req_val = 1'b0;
    tick();
    chk1 ("to_err_1cy",   bus.arb_timeout_err, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
